core_branch_redirect_ctrl: RTL and testbench
============================================

// Module: core_branch_redirect_ctrl
// PURPOSE
//  Sequences the EX-stage branch unit: enables it for each resolved branch/jump, compares the outcome
//  against the fetch prediction, and raises a held redirect (valid/ready) to fetch on a mispredict.
//  Drives pipeline flush/stall while the redirect drains, and flags misaligned-target exceptions to the trap logic.
//  Keeps saturating branch and mispredict statistics counters.
// PARAMETERS
//  XLEN          64  datapath/PC width
//  FLUSH_CYCLES  2   cycles o_flush stays high after the redirect handshake (legal range >=1)
//  CNT_W         16  width of statistics counters
// PORTS
//  i_clk                 in   1      core clock
//  i_rst_n               in   1      reset (asynchronous, active-low)
//  i_br_valid            in   1      EX holds a branch/jump to resolve this cycle
//  i_br_is_jump          in   1      unconditional jump (taken regardless of compare)
//  i_br_pred_taken       in   1      fetch prediction for this branch
//  i_br_pc               in   XLEN   PC of the branch
//  i_br_target           in   XLEN   computed taken target
//  i_br_taken            in   1      branch unit istaken result
//  i_br_addr_mismatch    in   1      branch unit misaligned-target flag
//  i_redirect_ready      in   1      fetch accepts redirect
//  i_cnt_clr             in   1      synchronous clear of statistics counters
//  o_br_enable           out  1      enable to branch unit
//  o_redirect_valid      out  1      redirect request to fetch
//  o_redirect_pc         out  XLEN   redirect PC
//  o_flush               out  1      flush IF/ID younger instructions
//  o_stall_ex            out  1      hold EX; new branches not accepted
//  o_misalign_exc        out  1      one-cycle pulse: misaligned branch target
//  o_misalign_tval       out  XLEN   faulting target address
//  o_branch_cnt          out  CNT_W  resolved branches (saturating)
//  o_mispred_cnt         out  CNT_W  mispredicts (saturating)
// BEHAVIOUR
//  - Reset: state IDLE; all registered outputs 0 (redirect_valid/pc, flush, stall_ex, misalign_exc/tval, counters).
//    Reset mid-redirect or mid-drain abandons it immediately; no redirect or flush resumes after reset release.
//  - o_br_enable = i_br_valid & (state==IDLE), combinational; 0 in all other states.
//  - FSM IDLE/REDIRECT/DRAIN. Accepted branch = i_br_valid in IDLE. actual_taken = i_br_is_jump | i_br_taken.
//  - IDLE, accepted, i_br_addr_mismatch=1: next cycle o_misalign_exc=1 for exactly 1 cycle,
//    o_misalign_tval=i_br_target (held until next exception); no redirect, no mispredict count; stay IDLE.
//  - IDLE, accepted, no mismatch, actual_taken!=i_br_pred_taken: mispredict. Next cycle state=REDIRECT,
//    o_redirect_valid=1, o_flush=1, o_stall_ex=1, o_redirect_pc = actual_taken ? i_br_target : i_br_pc+4
//    (modulo 2^XLEN, wraps). Correct prediction: no action, stay IDLE.
//  - REDIRECT: redirect_valid and redirect_pc held stable until i_redirect_ready=1 (handshake may complete in
//    the first REDIRECT cycle). On handshake: redirect_valid drops next cycle, go DRAIN with count=FLUSH_CYCLES.
//  - DRAIN: o_flush=1, o_stall_ex=1 for FLUSH_CYCLES cycles, then IDLE with flush/stall 0.
//    First new branch may be accepted in the first IDLE cycle.
//  - i_br_valid outside IDLE is ignored (EX is stalled; upstream holds the branch).
//  - Counters: branch_cnt +1 per accepted branch (mismatch included); mispred_cnt +1 per mispredict.
//    Both saturate at all-ones. i_cnt_clr same cycle as increment: clear wins, value 0.
//  - Latency: mispredict detect -> redirect_valid = 1 cycle; handshake -> IDLE = FLUSH_CYCLES+1 cycles.
// TESTING
//  - BEQ pred not-taken, taken=1, target=0x1000, ready=1: next cycle redirect_valid=1, pc=0x1000, flush=1;
//    then 2 drain cycles, then IDLE; mispred_cnt=1, branch_cnt=1.
//  - Pred taken, actual not-taken, pc=0xFFFF_FFFF_FFFF_FFFC: redirect_pc=0x0 (wrap);
//    ready low 5 cycles: valid/pc stable, stall_ex=1 throughout.
//  - Taken with addr_mismatch, target=0x2002: misalign_exc 1-cycle pulse, tval=0x2002,
//    no redirect_valid, mispred_cnt unchanged, branch_cnt+1.
//  - i_br_valid held during REDIRECT/DRAIN: o_br_enable=0, counters unchanged until IDLE; correct predictions cause no flush.
//  - Assert i_rst_n=0 while in REDIRECT: outputs 0 asynchronously; after release, IDLE with no redirect.
//  - Preload mispred_cnt to all-ones: further mispredicts hold value; i_cnt_clr with concurrent mispredict -> 0.

Source files
------------

// File: rtl/core_branch_redirect_ctrl.sv
// core_branch_redirect_ctrl
//   Sequences the EX-stage branch unit. Each branch resolved in IDLE is checked against the fetch
//   prediction. A mispredict raises a held redirect to fetch (valid/ready), then drives flush/stall
//   until the pipeline drains. A misaligned target raises a one-cycle exception pulse for the trap
//   logic. Saturating statistics counters track resolved branches and mispredicts.
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_br_*                  branch from EX: valid, jump, prediction, pc, target, taken, misalign
//   i_redirect_ready        fetch accepts the redirect
//   i_cnt_clr               synchronous clear of the statistics counters
//   o_br_enable             branch unit enable (combinational)
//   o_redirect_valid/_pc    redirect request to fetch
//   o_flush, o_stall_ex     flush younger instructions / hold EX
//   o_misalign_exc/_tval    misaligned-target pulse and faulting address
//   o_branch_cnt            resolved branches (saturating)
//   o_mispred_cnt           mispredicts (saturating)
module core_branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_br_valid,
  input  logic             i_br_is_jump,
  input  logic             i_br_pred_taken,
  input  logic [XLEN-1:0]  i_br_pc,
  input  logic [XLEN-1:0]  i_br_target,
  input  logic             i_br_taken,
  input  logic             i_br_addr_mismatch,
  input  logic             i_redirect_ready,
  input  logic             i_cnt_clr,
  output logic             o_br_enable,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_stall_ex,
  output logic             o_misalign_exc,
  output logic [XLEN-1:0]  o_misalign_tval,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int unsigned DCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [DCW-1:0] DrainInit = DCW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StIdle, StRedirect, StDrain} state_e;

  state_e             state_q;
  logic [DCW-1:0]     drain_q;
  logic               redirect_valid_q;
  logic [XLEN-1:0]    redirect_pc_q;
  logic               flush_q;
  logic               stall_q;
  logic               misalign_exc_q;
  logic [XLEN-1:0]    misalign_tval_q;
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mispred_cnt_q;

  logic accepted;
  logic actual_taken;
  logic mispredict;

  assign accepted     = i_br_valid & (state_q == StIdle);
  assign actual_taken = i_br_is_jump | i_br_taken;
  // A misaligned target traps instead of redirecting, so it never counts as a mispredict.
  assign mispredict   = accepted & ~i_br_addr_mismatch & (actual_taken != i_br_pred_taken);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= StIdle;
      drain_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      misalign_exc_q   <= 1'b0;
      misalign_tval_q  <= '0;
    end else begin
      misalign_exc_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accepted && i_br_addr_mismatch) begin
            misalign_exc_q  <= 1'b1;
            misalign_tval_q <= i_br_target;
          end else if (mispredict) begin
            state_q          <= StRedirect;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= actual_taken ? i_br_target : (i_br_pc + XLEN'(4));
            flush_q          <= 1'b1;
            stall_q          <= 1'b1;
          end
        end
        StRedirect: begin
          // Valid and pc stay put until fetch takes them.
          if (i_redirect_ready) begin
            state_q          <= StDrain;
            redirect_valid_q <= 1'b0;
            drain_q          <= DrainInit;
          end
        end
        StDrain: begin
          if (drain_q <= DCW'(1)) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (i_cnt_clr) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (accepted && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_br_enable      = accepted;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_flush          = flush_q;
  assign o_stall_ex       = stall_q;
  assign o_misalign_exc   = misalign_exc_q;
  assign o_misalign_tval  = misalign_tval_q;
  assign o_branch_cnt     = branch_cnt_q;
  assign o_mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_core_branch_redirect_ctrl.sv
// Bench for core_branch_redirect_ctrl: directed vector table, hand-written reset and saturation
// sequences, then random stimulus checked against a cycle model of the branch/redirect rules.
module tb_core_branch_redirect_ctrl;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned FLUSH  = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int          CNTMAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             br_valid, br_is_jump, br_pred_taken, br_taken, br_addr_mismatch;
  logic [XLEN-1:0]  br_pc, br_target;
  logic             redirect_ready, cnt_clr;
  logic             br_enable, redirect_valid, flush, stall_ex, misalign_exc;
  logic [XLEN-1:0]  redirect_pc, misalign_tval;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int n_checks = 0;
  int n_errors = 0;

  core_branch_redirect_ctrl #(
    .XLEN        (XLEN),
    .FLUSH_CYCLES(FLUSH),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_br_valid        (br_valid),
    .i_br_is_jump      (br_is_jump),
    .i_br_pred_taken   (br_pred_taken),
    .i_br_pc           (br_pc),
    .i_br_target       (br_target),
    .i_br_taken        (br_taken),
    .i_br_addr_mismatch(br_addr_mismatch),
    .i_redirect_ready  (redirect_ready),
    .i_cnt_clr         (cnt_clr),
    .o_br_enable       (br_enable),
    .o_redirect_valid  (redirect_valid),
    .o_redirect_pc     (redirect_pc),
    .o_flush           (flush),
    .o_stall_ex        (stall_ex),
    .o_misalign_exc    (misalign_exc),
    .o_misalign_tval   (misalign_tval),
    .o_branch_cnt      (branch_cnt),
    .o_mispred_cnt     (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            valid, jump, pred, taken, mism, ready, clr;
    logic [XLEN-1:0] pc, target;
    logic            exp_en, exp_rv, exp_fs, exp_exc;
    logic [XLEN-1:0] exp_rpc, exp_tval;
    int              exp_b, exp_m;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic valid, jump, pred, taken, mism, ready, clr,
                              input logic [XLEN-1:0] pc, target,
                              input logic en, rv, input logic [XLEN-1:0] rpc,
                              input logic fs, exc, input logic [XLEN-1:0] tval,
                              input int b, m);
    vec_t v;
    v.valid = valid; v.jump = jump; v.pred = pred; v.taken = taken; v.mism = mism;
    v.ready = ready; v.clr = clr; v.pc = pc; v.target = target;
    v.exp_en = en; v.exp_rv = rv; v.exp_rpc = rpc; v.exp_fs = fs; v.exp_exc = exc;
    v.exp_tval = tval; v.exp_b = b; v.exp_m = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    br_valid = v.valid; br_is_jump = v.jump; br_pred_taken = v.pred; br_taken = v.taken;
    br_addr_mismatch = v.mism; redirect_ready = v.ready; cnt_clr = v.clr;
    br_pc = v.pc; br_target = v.target;
  endtask

  // Entered at posedge+1: drive, sample enable at negedge, sample registers at next posedge+1.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".br_enable"}, 64'(br_enable), 64'(v.exp_en));
    @(posedge clk);
    #1;
    chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(v.exp_rv));
    chk({tag, ".redirect_pc"}, redirect_pc, v.exp_rpc);
    chk({tag, ".flush"}, 64'(flush), 64'(v.exp_fs));
    chk({tag, ".stall_ex"}, 64'(stall_ex), 64'(v.exp_fs));
    chk({tag, ".misalign_exc"}, 64'(misalign_exc), 64'(v.exp_exc));
    chk({tag, ".misalign_tval"}, misalign_tval, v.exp_tval);
    chk({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(v.exp_b));
    chk({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(v.exp_m));
  endtask

  // Plain single-cycle drive used by the longer sequences.
  task automatic tick(input logic valid, pred, taken, ready, clr);
    br_valid = valid; br_is_jump = 1'b0; br_pred_taken = pred; br_taken = taken;
    br_addr_mismatch = 1'b0; redirect_ready = ready; cnt_clr = clr;
    br_pc = 64'h100; br_target = 64'h200;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: redirect pending flag, remaining drain cycles, pulse, counters.
  logic            m_rv;
  logic [XLEN-1:0] m_rpc;
  int              m_drain;
  logic            m_exc;
  logic [XLEN-1:0] m_tval;
  int              m_b, m_m;

  task automatic model_reset();
    m_rv = 0; m_rpc = '0; m_drain = 0; m_exc = 0; m_tval = '0; m_b = 0; m_m = 0;
  endtask

  function automatic logic model_idle();
    return !m_rv && (m_drain == 0);
  endfunction

  task automatic model_step(input vec_t v);
    logic acc, act, mis;
    acc = v.valid && model_idle();
    act = v.jump || v.taken;
    mis = acc && !v.mism && (act != v.pred);
    m_exc = acc && v.mism;
    if (m_exc) m_tval = v.target;
    if (m_rv) begin
      if (v.ready) begin
        m_rv = 0;
        m_drain = FLUSH;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (mis) begin
      m_rv = 1;
      m_rpc = act ? v.target : v.pc + 64'd4;
    end
    if (v.clr) begin
      m_b = 0;
      m_m = 0;
    end else begin
      if (acc && m_b < CNTMAX) m_b++;
      if (mis && m_m < CNTMAX) m_m++;
    end
  endtask

  initial begin
    vec_t v;
    vec_t idle_v;
    idle_v = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table; expectations after each clock edge.
    tbl[0]  = mk(1, 0, 0, 1, 0, 1, 0, 64'h800, 64'h1000, 1, 1, 64'h1000, 1, 0, 64'h0, 1, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 64'h1000, 1, 0, 64'h0, 1, 1);
    tbl[2]  = mk(1, 0, 1, 1, 0, 1, 0, 64'h900, 64'h1100, 0, 0, 64'h1000, 1, 0, 64'h0, 1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 64'h1000, 0, 0, 64'h0, 1, 1);
    tbl[4]  = mk(1, 1, 0, 0, 1, 1, 0, 64'hA00, 64'h2002, 1, 0, 64'h1000, 0, 1, 64'h2002, 2, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 64'h1000, 0, 0, 64'h2002, 2, 1);
    tbl[6]  = mk(1, 0, 1, 1, 0, 1, 0, 64'hB00, 64'h3000, 1, 0, 64'h1000, 0, 0, 64'h2002, 3, 1);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4000,
                 1, 1, 64'h0, 1, 0, 64'h2002, 4, 2);
    for (int i = 8; i < 13; i++)
      tbl[i] = mk(1, 0, 0, 1, 0, 0, 0, 64'hC00, 64'h5000, 0, 1, 64'h0, 1, 0, 64'h2002, 4, 2);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 64'h0, 1, 0, 64'h2002, 4, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 64'h0, 1, 0, 64'h2002, 4, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 0, 64'h2002, 4, 2);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 0, 64'hD00, 64'h6000, 1, 0, 64'h0, 0, 0, 64'h2002, 5, 2);

    do_reset();
    chk("reset.redirect_valid", 64'(redirect_valid), 64'h0);
    chk("reset.flush", 64'(flush), 64'h0);
    chk("reset.stall_ex", 64'(stall_ex), 64'h0);
    chk("reset.misalign_tval", misalign_tval, 64'h0);
    chk("reset.branch_cnt", 64'(branch_cnt), 64'h0);

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Reset while a redirect is held: outputs drop asynchronously, nothing resumes.
    tick(1, 0, 1, 0, 0);
    chk("rstmid.pre_valid", 64'(redirect_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.redirect_valid", 64'(redirect_valid), 64'h0);
    chk("rstmid.flush", 64'(flush), 64'h0);
    chk("rstmid.stall_ex", 64'(stall_ex), 64'h0);
    chk("rstmid.redirect_pc", redirect_pc, 64'h0);
    chk("rstmid.mispred_cnt", 64'(mispred_cnt), 64'h0);
    drive(idle_v);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstrel.redirect_valid", 64'(redirect_valid), 64'h0);
    chk("rstrel.flush", 64'(flush), 64'h0);
    br_valid = 1'b1;
    #1;
    chk("rstrel.br_enable", 64'(br_enable), 64'h1);
    br_valid = 1'b0;
    @(posedge clk);
    #1;

    // Saturation: more mispredicts than the counters can hold, then clear with a mispredict.
    do_reset();
    for (int i = 0; i < CNTMAX + 5; i++) begin
      tick(1, 0, 1, 1, 0);
      repeat (FLUSH + 1) tick(0, 0, 0, 1, 0);
    end
    chk("sat.mispred_cnt", 64'(mispred_cnt), 64'(CNTMAX));
    chk("sat.branch_cnt", 64'(branch_cnt), 64'(CNTMAX));
    tick(1, 0, 1, 1, 0);
    chk("sat.hold_mispred", 64'(mispred_cnt), 64'(CNTMAX));
    repeat (FLUSH + 1) tick(0, 0, 0, 1, 0);
    tick(1, 0, 1, 1, 1);
    chk("clr.mispred_cnt", 64'(mispred_cnt), 64'h0);
    chk("clr.branch_cnt", 64'(branch_cnt), 64'h0);
    chk("clr.redirect_valid", 64'(redirect_valid), 64'h1);
    repeat (FLUSH + 1) tick(0, 0, 0, 1, 0);
    tick(1, 1, 1, 1, 0);
    chk("clr.after_branch", 64'(branch_cnt), 64'h1);
    chk("clr.after_mispred", 64'(mispred_cnt), 64'h0);

    // Random stimulus against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      v.valid = ($urandom_range(0, 1) == 1);
      v.jump  = ($urandom_range(0, 4) == 0);
      v.pred  = $urandom_range(0, 1) == 1;
      v.taken = $urandom_range(0, 1) == 1;
      v.mism  = ($urandom_range(0, 9) == 0);
      v.ready = ($urandom_range(0, 2) != 0);
      v.clr   = ($urandom_range(0, 40) == 0);
      v.pc     = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      v.target = {$urandom, $urandom};
      drive(v);
      @(negedge clk);
      chk("rnd.br_enable", 64'(br_enable), 64'(v.valid && model_idle()));
      @(posedge clk);
      model_step(v);
      #1;
      chk("rnd.redirect_valid", 64'(redirect_valid), 64'(m_rv));
      if (m_rv) chk("rnd.redirect_pc", redirect_pc, m_rpc);
      chk("rnd.flush", 64'(flush), 64'(m_rv || m_drain > 0));
      chk("rnd.stall_ex", 64'(stall_ex), 64'(m_rv || m_drain > 0));
      chk("rnd.misalign_exc", 64'(misalign_exc), 64'(m_exc));
      chk("rnd.misalign_tval", misalign_tval, m_tval);
      chk("rnd.branch_cnt", 64'(branch_cnt), 64'(m_b));
      chk("rnd.mispred_cnt", 64'(mispred_cnt), 64'(m_m));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
